// File: rtl/issue_scheduler.sv
// In-order single-issue scheduler: RAW/WAW/structural/writeback-port hazard checks,
// per-register pending state and a writeback reservation pipeline.
module issue_scheduler #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned LAT0      = 1,
    parameter int unsigned LAT1      = 3,
    parameter int unsigned LAT2      = 5,
    parameter int unsigned LAT3      = 2,
    parameter logic [3:0]  PIPELINED = 4'b0001,
    parameter int unsigned MAX_LAT   = 8
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    input  logic [$clog2(NUM_REGS)-1:0] in_rs_i,
    input  logic [$clog2(NUM_REGS)-1:0] in_rt_i,
    input  logic [$clog2(NUM_REGS)-1:0] in_rd_i,
    input  logic [1:0]                  in_fu_i,
    output logic                        in_ready_o,
    output logic [2:0]                  stall_cause_o,
    output logic                        issue_valid_o,
    output logic [1:0]                  issue_fu_o,
    output logic [$clog2(NUM_REGS)-1:0] issue_rd_o,
    output logic                        wb_valid_o,
    output logic [$clog2(NUM_REGS)-1:0] wb_rd_o,
    output logic [1:0]                  wb_fu_o,
    output logic [NUM_REGS-1:0]         pnd_sgn_o
);
    localparam int unsigned RW = $clog2(NUM_REGS);
    localparam int unsigned CW = $clog2(MAX_LAT + 1);

    logic [NUM_REGS-1:0]          pnd_q, pnd_d;
    logic [NUM_REGS-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [3:0]                   busy_q, busy_d;
    // Slot i holds the op that writes back at the (i+1)-th upcoming edge.
    logic [MAX_LAT-1:0]           res_vld_q, res_vld_d;
    logic [MAX_LAT-1:0][RW-1:0]   res_rd_q, res_rd_d;
    logic [MAX_LAT-1:0][1:0]      res_fu_q, res_fu_d;
    logic                         issue_valid_q, issue_valid_d;
    logic [1:0]                   issue_fu_q, issue_fu_d;
    logic [RW-1:0]                issue_rd_q, issue_rd_d;
    logic                         wb_valid_q, wb_valid_d;
    logic [RW-1:0]                wb_rd_q, wb_rd_d;
    logic [1:0]                   wb_fu_q, wb_fu_d;

    logic [CW-1:0]  lat;
    logic [MAX_LAT:0] res_pad;
    logic           raw, waw, fu_busy, wb_conflict, accept;

    always_comb begin
        unique case (in_fu_i)
            2'd0: lat = CW'(LAT0);
            2'd1: lat = CW'(LAT1);
            2'd2: lat = CW'(LAT2);
            default: lat = CW'(LAT3);
        endcase
    end

    // Slot index L in the pre-edge view is the edge t0+L; L = MAX_LAT can never be taken.
    assign res_pad     = {1'b0, res_vld_q};
    assign raw         = pnd_q[in_rs_i] | pnd_q[in_rt_i];
    assign waw         = pnd_q[in_rd_i];
    assign fu_busy     = busy_q[in_fu_i];
    assign wb_conflict = res_pad[lat];

    always_comb begin
        stall_cause_o = 3'd0;
        if (raw)              stall_cause_o = 3'd1;
        else if (waw)         stall_cause_o = 3'd2;
        else if (fu_busy)     stall_cause_o = 3'd3;
        else if (wb_conflict) stall_cause_o = 3'd4;
    end

    assign in_ready_o = (stall_cause_o == 3'd0) & ~flush_i;
    assign accept     = in_valid_i & in_ready_o;

    always_comb begin
        pnd_d     = pnd_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        res_vld_d = {1'b0, res_vld_q[MAX_LAT-1:1]};
        res_rd_d  = {RW'(0), res_rd_q[MAX_LAT-1:1]};
        res_fu_d  = {2'd0, res_fu_q[MAX_LAT-1:1]};
        for (int r = 1; r < NUM_REGS; r++) begin
            if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
                if (cnt_q[r] == CW'(1)) pnd_d[r] = 1'b0;
            end
        end
        if (res_vld_q[0] && !PIPELINED[res_fu_q[0]]) busy_d[res_fu_q[0]] = 1'b0;
        if (accept) begin
            if (in_rd_i != '0) begin
                cnt_d[in_rd_i] = lat;
                pnd_d[in_rd_i] = 1'b1;
            end
            if (!PIPELINED[in_fu_i]) busy_d[in_fu_i] = 1'b1;
            res_vld_d[lat - 1'b1] = 1'b1;
            res_rd_d[lat - 1'b1]  = in_rd_i;
            res_fu_d[lat - 1'b1]  = in_fu_i;
        end
    end

    always_comb begin
        issue_valid_d = accept;
        issue_fu_d    = accept ? in_fu_i : issue_fu_q;
        issue_rd_d    = accept ? in_rd_i : issue_rd_q;
        wb_valid_d    = res_vld_q[0];
        wb_rd_d       = res_vld_q[0] ? res_rd_q[0] : '0;
        wb_fu_d       = res_vld_q[0] ? res_fu_q[0] : '0;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pnd_q         <= '0;
            cnt_q         <= '0;
            busy_q        <= '0;
            res_vld_q     <= '0;
            res_rd_q      <= '0;
            res_fu_q      <= '0;
            issue_valid_q <= 1'b0;
            issue_fu_q    <= '0;
            issue_rd_q    <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_fu_q       <= '0;
        end else if (flush_i) begin
            pnd_q         <= '0;
            cnt_q         <= '0;
            busy_q        <= '0;
            res_vld_q     <= '0;
            res_rd_q      <= '0;
            res_fu_q      <= '0;
            issue_valid_q <= 1'b0;
            issue_fu_q    <= '0;
            issue_rd_q    <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_fu_q       <= '0;
        end else begin
            pnd_q         <= pnd_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            res_vld_q     <= res_vld_d;
            res_rd_q      <= res_rd_d;
            res_fu_q      <= res_fu_d;
            issue_valid_q <= issue_valid_d;
            issue_fu_q    <= issue_fu_d;
            issue_rd_q    <= issue_rd_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_fu_q       <= wb_fu_d;
        end
    end

    assign issue_valid_o = issue_valid_q;
    assign issue_fu_o    = issue_fu_q;
    assign issue_rd_o    = issue_rd_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_rd_o       = wb_rd_q;
    assign wb_fu_o       = wb_fu_q;
    assign pnd_sgn_o     = pnd_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: hazards, latencies, r0 handling, flush and async reset.
module tb_issue_scheduler;
    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [4:0]  in_rs_i = '0, in_rt_i = '0, in_rd_i = '0;
    logic [1:0]  in_fu_i = '0;
    logic        in_ready_o, issue_valid_o, wb_valid_o;
    logic [2:0]  stall_cause_o;
    logic [1:0]  issue_fu_o, wb_fu_o;
    logic [4:0]  issue_rd_o, wb_rd_o;
    logic [31:0] pnd_sgn_o;

    int checks = 0;
    int errors = 0;

    issue_scheduler dut (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_rs_i(in_rs_i), .in_rt_i(in_rt_i),
        .in_rd_i(in_rd_i), .in_fu_i(in_fu_i),
        .in_ready_o(in_ready_o), .stall_cause_o(stall_cause_o),
        .issue_valid_o(issue_valid_o), .issue_fu_o(issue_fu_o), .issue_rd_o(issue_rd_o),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_fu_o(wb_fu_o),
        .pnd_sgn_o(pnd_sgn_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [1:0] fu);
        in_valid_i = 1'b1; in_rs_i = rs; in_rt_i = rt; in_rd_i = rd; in_fu_i = fu;
        #1;
    endtask

    task automatic idle();
        in_valid_i = 1'b0; in_rs_i = '0; in_rt_i = '0; in_rd_i = '0; in_fu_i = '0;
    endtask

    task automatic reset_dut();
        idle();
        flush_i = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_i = 1'b1;
        #2;
        checks++;
        if ({issue_valid_o, issue_fu_o, issue_rd_o, wb_valid_o, wb_rd_o, wb_fu_o} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {issue_valid_o, issue_fu_o, issue_rd_o, wb_valid_o, wb_rd_o, wb_fu_o});
        end
        checks++;
        if (pnd_sgn_o !== 32'h0) begin
            errors++; $display("FAIL reset_pnd got %h want 0", pnd_sgn_o);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", in_ready_o);
        end
    endtask

    task automatic test_single_alu();
        reset_dut();
        present(5'd0, 5'd0, 5'd3, 2'd0);
        checks++;
        if (in_ready_o !== 1'b1 || stall_cause_o !== 3'd0) begin
            errors++; $display("FAIL alu_ready got %b/%0d want 1/0", in_ready_o, stall_cause_o);
        end
        tick();
        idle();
        checks++;
        if (issue_valid_o !== 1'b1 || issue_rd_o !== 5'd3 || issue_fu_o !== 2'd0) begin
            errors++;
            $display("FAIL alu_issue got v%b rd%0d fu%0d want v1 rd3 fu0",
                     issue_valid_o, issue_rd_o, issue_fu_o);
        end
        checks++;
        if (pnd_sgn_o !== 32'h8 || wb_valid_o !== 1'b0) begin
            errors++; $display("FAIL alu_pnd got %h/wb%b want 8/wb0", pnd_sgn_o, wb_valid_o);
        end
        tick();
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd3 || wb_fu_o !== 2'd0 || pnd_sgn_o !== 32'h0) begin
            errors++;
            $display("FAIL alu_wb got v%b rd%0d fu%0d pnd%h want v1 rd3 fu0 pnd0",
                     wb_valid_o, wb_rd_o, wb_fu_o, pnd_sgn_o);
        end
        tick();
        checks++;
        if (wb_valid_o !== 1'b0 || issue_valid_o !== 1'b0) begin
            errors++; $display("FAIL alu_quiet got wb%b iss%b want 0/0", wb_valid_o, issue_valid_o);
        end
    endtask

    task automatic test_raw();
        int n;
        reset_dut();
        present(5'd0, 5'd0, 5'd5, 2'd1);
        tick();
        present(5'd5, 5'd1, 5'd6, 2'd0);
        n = 0;
        while (!in_ready_o && n < 10) begin
            checks++;
            if (stall_cause_o !== 3'd1) begin
                errors++; $display("FAIL raw_cause got %0d want 1", stall_cause_o);
            end
            n++;
            tick();
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL raw_stall_cycles got %0d want 3", n);
        end
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd5 || wb_fu_o !== 2'd1) begin
            errors++;
            $display("FAIL raw_mul_wb got v%b rd%0d fu%0d want v1 rd5 fu1",
                     wb_valid_o, wb_rd_o, wb_fu_o);
        end
        tick();
        idle();
        checks++;
        if (issue_valid_o !== 1'b1 || issue_rd_o !== 5'd6 || pnd_sgn_o !== 32'h40) begin
            errors++;
            $display("FAIL raw_add_issue got v%b rd%0d pnd%h want v1 rd6 pnd40",
                     issue_valid_o, issue_rd_o, pnd_sgn_o);
        end
        tick();
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd6 || pnd_sgn_o !== 32'h0) begin
            errors++;
            $display("FAIL raw_add_wb got v%b rd%0d pnd%h want v1 rd6 pnd0",
                     wb_valid_o, wb_rd_o, pnd_sgn_o);
        end
    endtask

    task automatic test_fu_busy();
        int n;
        reset_dut();
        present(5'd0, 5'd0, 5'd7, 2'd2);
        tick();
        present(5'd0, 5'd0, 5'd8, 2'd2);
        n = 0;
        while (!in_ready_o && n < 12) begin
            checks++;
            if (stall_cause_o !== 3'd3) begin
                errors++; $display("FAIL div_cause got %0d want 3", stall_cause_o);
            end
            n++;
            tick();
        end
        checks++;
        if (n != 5 || wb_valid_o !== 1'b1 || wb_rd_o !== 5'd7 || wb_fu_o !== 2'd2) begin
            errors++;
            $display("FAIL div_release got n%0d v%b rd%0d fu%0d want n5 v1 rd7 fu2",
                     n, wb_valid_o, wb_rd_o, wb_fu_o);
        end
        tick();
        idle();
        checks++;
        if (issue_valid_o !== 1'b1 || issue_rd_o !== 5'd8 || pnd_sgn_o !== 32'h100) begin
            errors++;
            $display("FAIL div_second got v%b rd%0d pnd%h want v1 rd8 pnd100",
                     issue_valid_o, issue_rd_o, pnd_sgn_o);
        end
    endtask

    task automatic test_wb_conflict();
        reset_dut();
        present(5'd0, 5'd0, 5'd9, 2'd3);
        tick();
        present(5'd0, 5'd0, 5'd10, 2'd0);
        checks++;
        if (stall_cause_o !== 3'd4 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL wbc_cause got %0d rdy%b want 4 rdy0", stall_cause_o, in_ready_o);
        end
        tick();
        checks++;
        if (in_ready_o !== 1'b1 || pnd_sgn_o !== 32'h200) begin
            errors++;
            $display("FAIL wbc_ready got rdy%b pnd%h want rdy1 pnd200", in_ready_o, pnd_sgn_o);
        end
        tick();
        idle();
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd9 || wb_fu_o !== 2'd3 || issue_rd_o !== 5'd10) begin
            errors++;
            $display("FAIL wbc_first got v%b rd%0d fu%0d iss%0d want v1 rd9 fu3 iss10",
                     wb_valid_o, wb_rd_o, wb_fu_o, issue_rd_o);
        end
        tick();
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd10 || wb_fu_o !== 2'd0) begin
            errors++;
            $display("FAIL wbc_second got v%b rd%0d fu%0d want v1 rd10 fu0",
                     wb_valid_o, wb_rd_o, wb_fu_o);
        end
    endtask

    task automatic test_back_to_back_r0();
        reset_dut();
        present(5'd0, 5'd0, 5'd0, 2'd0);
        tick();
        checks++;
        if (issue_valid_o !== 1'b1 || pnd_sgn_o !== 32'h0) begin
            errors++; $display("FAIL r0_issue got v%b pnd%h want v1 pnd0", issue_valid_o, pnd_sgn_o);
        end
        present(5'd0, 5'd0, 5'd1, 2'd0);
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++; $display("FAIL r0_no_raw got rdy%b cause%0d want rdy1", in_ready_o, stall_cause_o);
        end
        tick();
        idle();
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd0 || pnd_sgn_o !== 32'h2 || issue_rd_o !== 5'd1) begin
            errors++;
            $display("FAIL r0_wb got v%b rd%0d pnd%h iss%0d want v1 rd0 pnd2 iss1",
                     wb_valid_o, wb_rd_o, pnd_sgn_o, issue_rd_o);
        end
        tick();
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd1 || pnd_sgn_o !== 32'h0) begin
            errors++;
            $display("FAIL r1_wb got v%b rd%0d pnd%h want v1 rd1 pnd0", wb_valid_o, wb_rd_o, pnd_sgn_o);
        end
    endtask

    task automatic test_flush_and_reset();
        reset_dut();
        present(5'd0, 5'd0, 5'd4, 2'd1);
        tick();
        idle();
        tick();
        flush_i = 1'b1;
        present(5'd0, 5'd0, 5'd11, 2'd0);
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++; $display("FAIL flush_ready got %b want 0", in_ready_o);
        end
        tick();
        flush_i = 1'b0;
        idle();
        checks++;
        if (pnd_sgn_o !== 32'h0 || wb_valid_o !== 1'b0 || issue_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got pnd%h wb%b iss%b want 0/0/0",
                     pnd_sgn_o, wb_valid_o, issue_valid_o);
        end
        present(5'd0, 5'd0, 5'd4, 2'd1);
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_reaccept got rdy%b cause%0d want rdy1", in_ready_o, stall_cause_o);
        end
        tick();
        idle();
        checks++;
        if (issue_valid_o !== 1'b1 || pnd_sgn_o !== 32'h10 || wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_stale got iss%b pnd%h wb%b want 1/10/0",
                     issue_valid_o, pnd_sgn_o, wb_valid_o);
        end
        tick();
        tick();
        checks++;
        if (wb_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_early_wb got %b want 0", wb_valid_o);
        end
        tick();
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd4) begin
            errors++; $display("FAIL flush_new_wb got v%b rd%0d want v1 rd4", wb_valid_o, wb_rd_o);
        end
        present(5'd0, 5'd0, 5'd4, 2'd1);
        tick();
        idle();
        #1;
        reset_i = 1'b1;
        #1;
        checks++;
        if (issue_valid_o !== 1'b0 || pnd_sgn_o !== 32'h0 || issue_rd_o !== 5'd0) begin
            errors++;
            $display("FAIL async_reset got iss%b pnd%h rd%0d want 0/0/0",
                     issue_valid_o, pnd_sgn_o, issue_rd_o);
        end
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (wb_valid_o !== 1'b0 || pnd_sgn_o !== 32'h0) begin
                errors++;
                $display("FAIL reset_residual got wb%b pnd%h want 0/0", wb_valid_o, pnd_sgn_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_raw();
        test_fu_busy();
        test_wb_conflict();
        test_back_to_back_r0();
        test_flush_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule
